branch_predictor: RTL and testbench

- Parametrised fetch-stage branch predictor: direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Fetch looks up `pcF` in the same cycle and gets a predicted next PC.
- Execute reports each resolved branch or jump; the block trains the table and flags mispredictions so the datapath can flush F/D and redirect.
- Replaces the always-not-taken fetch policy of the current 5-stage pipeline.

---
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pcF,
  output logic            pred_takenF,
  output logic [XLEN-1:0] pred_pcF,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_pc,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            inval,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic             r_jmp    [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;

  assign w_f_idx = pcF[IDX_W+1:2];
  assign w_f_tag = pcF[XLEN-1:IDX_W+2];
  assign w_u_idx = upd_pc[IDX_W+1:2];
  assign w_u_tag = upd_pc[XLEN-1:IDX_W+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  // Fetch-side lookup: purely combinational from pcF and the table state
  always_comb begin
    w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    pred_takenF = w_f_hit && (r_jmp[w_f_idx] || r_cnt[w_f_idx][CNT_W-1]);
    pred_pcF    = pred_takenF ? r_target[w_f_idx] : pcF + XLEN'(4);
  end

  // Execute-side misprediction detection and correct-path address
  always_comb begin
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_pred_pc != upd_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
  end

  // Table training; invalidate takes priority and drops a concurrent update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_jmp[i]    <= 1'b0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (inval) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_u_hit) begin
        if (upd_taken) begin
          if (r_cnt[w_u_idx] != CNT_MAX) begin
            r_cnt[w_u_idx] <= r_cnt[w_u_idx] + CNT_W'(1);
          end
          r_target[w_u_idx] <= upd_target;
          r_jmp[w_u_idx]    <= upd_is_jump;
        end else if (r_cnt[w_u_idx] != '0) begin
          r_cnt[w_u_idx] <= r_cnt[w_u_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= upd_target;
        r_jmp[w_u_idx]    <= upd_is_jump;
        r_cnt[w_u_idx]    <= CNT_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispred;

  // Event counters; they count updates even when inval drops them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (upd_valid)  r_stat_branches <= r_stat_branches + 32'd1;
      if (mispredict) r_stat_mispred  <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;
`else
  assign stat_branches = 32'd0;
  assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard testbench for branch_predictor
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pcF;
  logic        pred_takenF;
  logic [31:0] pred_pcF;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jump;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        inval;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .pcF(pcF),
    .pred_takenF(pred_takenF), .pred_pcF(pred_pcF),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
    .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .inval(inval),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ppc;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] m_sb = 0;
  logic [31:0] m_sm = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expected response per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".pred_taken"}, {31'd0, pred_takenF}, {31'd0, e.pt});
      chk({e.name, ".pred_pc"}, pred_pcF, e.ppc);
      chk({e.name, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.mp});
      if (e.mp) chk({e.name, ".redirect"}, redirect_pc, e.rd);
      chk({e.name, ".stat_br"}, stat_branches, e.sb);
      chk({e.name, ".stat_mp"}, stat_mispred, e.sm);
    end
  end

  // Drive one cycle of stimulus and queue its hand-computed response
  task automatic drive(input string nm, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic utk, input logic ujmp, input logic upt,
                       input logic [31:0] uppc, input logic inv,
                       input logic e_pt, input logic [31:0] e_ppc,
                       input logic e_mp, input logic [31:0] e_rd);
    exp_t e;
    pcF = pc; upd_valid = uv; upd_pc = upc; upd_target = utgt;
    upd_taken = utk; upd_is_jump = ujmp; upd_pred_taken = upt;
    upd_pred_pc = uppc; inval = inv;
    e.name = nm; e.pt = e_pt; e.ppc = e_ppc; e.mp = e_mp; e.rd = e_rd;
`ifdef BP_STATS_EN
    e.sb = m_sb; e.sm = m_sm;
    if (uv)   m_sb = m_sb + 1;
    if (e_mp) m_sm = m_sm + 1;
`else
    e.sb = 0; e.sm = 0;
`endif
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    pcF = 0; upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    upd_is_jump = 0; upd_pred_taken = 0; upd_pred_pc = 0; inval = 0;
    @(posedge clk); #1;
    //      name        pcF          uv upc          tgt          tk j pt ppc          inv  pt ppc          mp rd
    drive("rst0",     32'h100,      0, 32'h100,     32'h900,     1, 0, 0, 32'h104,     0,   0, 32'h104,     0, 0);
    drive("rst1",     32'h100,      0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   0, 32'h104,     0, 0);
    reset = 1'b1;
    drive("alloc",    32'h100,      1, 32'h100,     32'h200,     1, 0, 0, 32'h104,     0,   0, 32'h104,     1, 32'h200);
    drive("hit",      32'h100,      0, 32'h100,     32'h200,     1, 0, 0, 32'h104,     0,   1, 32'h200,     0, 0);
    drive("nt1",      32'h100,      1, 32'h100,     32'h200,     0, 0, 1, 32'h200,     0,   1, 32'h200,     1, 32'h104);
    drive("nt2",      32'h100,      1, 32'h100,     32'h200,     0, 0, 0, 32'h104,     0,   0, 32'h104,     0, 0);
    drive("nt3",      32'h100,      1, 32'h100,     32'h200,     0, 0, 0, 32'h104,     0,   0, 32'h104,     0, 0);
    drive("tk_lo",    32'h100,      1, 32'h100,     32'h200,     1, 0, 0, 32'h104,     0,   0, 32'h104,     1, 32'h200);
    drive("weak_nt",  32'h100,      0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   0, 32'h104,     0, 0);
    drive("alias",    32'h140,      1, 32'h140,     32'h400,     1, 1, 0, 32'h144,     0,   0, 32'h144,     1, 32'h400);
    drive("evicted",  32'h100,      0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   0, 32'h104,     0, 0);
    drive("jmp_hit",  32'h140,      1, 32'h140,     32'h400,     0, 0, 1, 32'h400,     0,   1, 32'h400,     1, 32'h144);
    drive("jmp_keep", 32'h140,      0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   1, 32'h400,     0, 0);
    drive("wrong_tg", 32'h300,      1, 32'h140,     32'h500,     1, 0, 1, 32'h400,     0,   0, 32'h304,     1, 32'h500);
    drive("same_cyc", 32'h300,      1, 32'h300,     32'h600,     1, 0, 0, 32'h304,     0,   0, 32'h304,     1, 32'h600);
    drive("after_sc", 32'h300,      1, 32'h300,     32'h600,     1, 0, 1, 32'h600,     0,   1, 32'h600,     0, 0);
    drive("inval",    32'h300,      1, 32'h140,     32'h700,     1, 0, 0, 32'h144,     1,   1, 32'h600,     1, 32'h700);
    drive("post_inv", 32'h300,      0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   0, 32'h304,     0, 0);
    drive("no_alloc", 32'h140,      0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   0, 32'h144,     0, 0);
    drive("wrap",     32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h10,     0, 0, 1, 32'h10,      0,   0, 32'h00000000, 1, 32'h00000000);
    drive("idx1",     32'h104,      1, 32'h104,     32'h800,     1, 0, 0, 32'h108,     0,   0, 32'h108,     1, 32'h800);
    drive("idx1_hit", 32'h104,      0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   1, 32'h800,     0, 0);
    drive("idx0_miss",32'h100,      0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   0, 32'h104,     0, 0);
    drive("final",    32'h0,        0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       0,   0, 32'h4,       0, 0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
